// File: rtl/set_assoc_cache_if.sv
// CPU request/response and main-memory signals of the set-associative cache.
// The slave modport is the cache side and the master modport is the CPU/memory side.
interface set_assoc_cache_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_en;
    logic                  is_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  data_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  data_vld_out;
    logic                  resp_vld;
    logic                  is_hit;
    logic                  cache_busy;
    logic [ADDR_WIDTH-1:0] addr_main;
    logic                  addr_main_rd_en;
    logic                  addr_main_wr_en;
    logic [LINE_WIDTH-1:0] data_main_wr;
    logic [LINE_WIDTH-1:0] data_main_rd;
    logic                  data_main_vld;
    logic [CNT_WIDTH-1:0]  hit_count;
    logic [CNT_WIDTH-1:0]  miss_count;

    modport slave (
        input  addr, addr_en, is_rd, wr_data, data_vld, data_main_rd, data_main_vld,
        output rd_data, data_vld_out, resp_vld, is_hit, cache_busy, addr_main,
               addr_main_rd_en, addr_main_wr_en, data_main_wr, hit_count, miss_count
    );

    modport master (
        output addr, addr_en, is_rd, wr_data, data_vld, data_main_rd, data_main_vld,
        input  rd_data, data_vld_out, resp_vld, is_hit, cache_busy, addr_main,
               addr_main_rd_en, addr_main_wr_en, data_main_wr, hit_count, miss_count
    );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with round-robin replacement,
// one outstanding request and saturating hit/miss counters.
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             flush,
    set_assoc_cache_if.slave bus
);
    localparam int OFFSET_W = $clog2(LINE_WIDTH / DATA_WIDTH);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - INDEX_W;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] reqAddr_q;
    logic                  reqRd_q;
    logic [DATA_WIDTH-1:0] reqData_q;
    logic [WAY_W-1:0]      way_q;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] addrMain_q;
    logic                  rdEn_q;
    logic                  wrEn_q;
    logic [LINE_WIDTH-1:0] dataMainWr_q;
    logic [CNT_WIDTH-1:0]  hitCnt_q;
    logic [CNT_WIDTH-1:0]  missCnt_q;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic [OFFSET_W-1:0]   reqOff;
    logic [INDEX_W-1:0]    reqIdx;
    logic [TAG_W-1:0]      reqTag;
    logic                  lookupHit;
    logic [WAY_W-1:0]      lookupWay;
    logic                  victimFound;
    logic [WAY_W-1:0]      victimWay;
    logic                  accept;
    logic                  enterWb;
    logic                  enterFill;

    assign reqOff    = reqAddr_q[OFFSET_W-1:0];
    assign reqIdx    = reqAddr_q[OFFSET_W +: INDEX_W];
    assign reqTag    = reqAddr_q[ADDR_WIDTH-1 -: TAG_W];
    assign accept    = (state_q == IDLE) && bus.addr_en && (bus.is_rd || bus.data_vld);
    assign enterWb   = (state_d == WRITEBACK) && (state_q != WRITEBACK);
    assign enterFill = (state_d == FILL) && (state_q != FILL);

    // Tag compare across the set, plus the replacement choice: first invalid way, else RR pointer.
    always_comb begin
        lookupHit   = 1'b0;
        lookupWay   = '0;
        victimFound = 1'b0;
        victimWay   = rr_q[reqIdx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!lookupHit && valid_q[reqIdx][w] && (tag_q[reqIdx][w] == reqTag)) begin
                lookupHit = 1'b1;
                lookupWay = WAY_W'(w);
            end
            if (!victimFound && !valid_q[reqIdx][w]) begin
                victimFound = 1'b1;
                victimWay   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOOKUP;
            LOOKUP: begin
                if (lookupHit)
                    state_d = RESPOND;
                else if (valid_q[reqIdx][victimWay] && dirty_q[reqIdx][victimWay])
                    state_d = WRITEBACK;
                else
                    state_d = FILL;
            end
            WRITEBACK: if (bus.data_main_vld) state_d = FILL;
            FILL:      if (bus.data_main_vld) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q      <= IDLE;
            reqAddr_q    <= '0;
            reqRd_q      <= 1'b0;
            reqData_q    <= '0;
            way_q        <= '0;
            hit_q        <= 1'b0;
            addrMain_q   <= '0;
            rdEn_q       <= 1'b0;
            wrEn_q       <= 1'b0;
            dataMainWr_q <= '0;
            hitCnt_q     <= '0;
            missCnt_q    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            rdEn_q  <= enterFill;
            wrEn_q  <= enterWb;
            if (accept) begin
                reqAddr_q <= bus.addr;
                reqRd_q   <= bus.is_rd;
                reqData_q <= bus.wr_data;
            end
            if (state_q == LOOKUP) begin
                hit_q <= lookupHit;
                way_q <= lookupHit ? lookupWay : victimWay;
            end
            if (enterWb) begin
                addrMain_q   <= {tag_q[reqIdx][victimWay], reqIdx, {OFFSET_W{1'b0}}};
                dataMainWr_q <= data_q[reqIdx][victimWay];
            end
            if (enterFill)
                addrMain_q <= {reqTag, reqIdx, {OFFSET_W{1'b0}}};
            if ((state_q == WRITEBACK) && bus.data_main_vld)
                valid_q[reqIdx][way_q] <= 1'b0;
            if ((state_q == FILL) && bus.data_main_vld) begin
                valid_q[reqIdx][way_q] <= 1'b1;
                dirty_q[reqIdx][way_q] <= 1'b0;
                rr_q[reqIdx] <= (rr_q[reqIdx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[reqIdx] + 1'b1;
            end
            if (state_q == RESPOND) begin
                if (!reqRd_q)
                    dirty_q[reqIdx][way_q] <= 1'b1;
                if (hit_q && (hitCnt_q != '1))
                    hitCnt_q <= hitCnt_q + 1'b1;
                if (!hit_q && (missCnt_q != '1))
                    missCnt_q <= missCnt_q + 1'b1;
            end
        end
    end

    // Line storage needs no reset: valid bits gate every use of tag and data.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if ((state_q == FILL) && bus.data_main_vld) begin
                tag_q[reqIdx][way_q]  <= reqTag;
                data_q[reqIdx][way_q] <= bus.data_main_rd;
            end
            if ((state_q == RESPOND) && !reqRd_q)
                data_q[reqIdx][way_q][int'(reqOff) * DATA_WIDTH +: DATA_WIDTH] <= reqData_q;
        end
    end

    assign bus.cache_busy      = (state_q != IDLE);
    assign bus.resp_vld        = (state_q == RESPOND);
    assign bus.is_hit          = (state_q == RESPOND) && hit_q;
    assign bus.data_vld_out    = (state_q == RESPOND) && reqRd_q;
    assign bus.rd_data         = bus.data_vld_out ?
                                 data_q[reqIdx][way_q][int'(reqOff) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.addr_main       = addrMain_q;
    assign bus.addr_main_rd_en = rdEn_q;
    assign bus.addr_main_wr_en = wrEn_q;
    assign bus.data_main_wr    = dataMainWr_q;
    assign bus.hit_count       = hitCnt_q;
    assign bus.miss_count      = missCnt_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: miss/hit latency, write allocate, dirty eviction,
// flush during a miss, ignored requests and counter saturation (second instance, CNT_WIDTH=2).
module tb_set_assoc_cache;
    logic clk;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    int          obsCycle;
    logic        obsHit;
    logic        obsDvo;
    logic [7:0]  obsRdData;
    logic        obsSawRd;
    logic        obsSawWr;
    logic [15:0] obsRdAddr;
    logic [15:0] obsWrAddr;
    logic [31:0] obsWrLine;
    logic        sawTraffic;

    set_assoc_cache_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(32)) bus ();
    set_assoc_cache_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

    set_assoc_cache #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LINE_WIDTH(32),
                      .NUM_SETS(4), .NUM_WAYS(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .flush(flush), .bus(bus.slave)
    );

    set_assoc_cache #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LINE_WIDTH(32),
                      .NUM_SETS(4), .NUM_WAYS(2), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .flush(flush), .bus(bus2.slave)
    );

    assign bus2.addr          = bus.addr;
    assign bus2.addr_en       = bus.addr_en;
    assign bus2.is_rd         = bus.is_rd;
    assign bus2.wr_data       = bus.wr_data;
    assign bus2.data_vld      = bus.data_vld;
    assign bus2.data_main_rd  = bus.data_main_rd;
    assign bus2.data_main_vld = bus.data_main_vld;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    // Issues one request at the current negedge and acts as main memory until the response.
    task automatic applyStimulus(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                                 input logic [31:0] fillLine);
        logic pendingAck;
        logic done;
        pendingAck = 1'b0;
        done       = 1'b0;
        obsCycle   = -1;
        obsHit     = 1'bx;
        obsDvo     = 1'bx;
        obsRdData  = 'x;
        obsSawRd   = 1'b0;
        obsSawWr   = 1'b0;
        obsRdAddr  = 'x;
        obsWrAddr  = 'x;
        obsWrLine  = 'x;
        bus.addr     = a;
        bus.is_rd    = rd;
        bus.wr_data  = wd;
        bus.data_vld = !rd;
        bus.addr_en  = 1'b1;
        @(negedge clk);
        bus.addr_en  = 1'b0;
        bus.data_vld = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            if (pendingAck) begin
                bus.data_main_vld = 1'b1;
                bus.data_main_rd  = fillLine;
                pendingAck        = 1'b0;
            end else begin
                bus.data_main_vld = 1'b0;
            end
            if (bus.addr_main_rd_en) begin
                obsSawRd   = 1'b1;
                obsRdAddr  = bus.addr_main;
                pendingAck = 1'b1;
            end
            if (bus.addr_main_wr_en) begin
                obsSawWr   = 1'b1;
                obsWrAddr  = bus.addr_main;
                obsWrLine  = bus.data_main_wr;
                pendingAck = 1'b1;
            end
            if (bus.resp_vld) begin
                obsCycle  = c;
                obsHit    = bus.is_hit;
                obsDvo    = bus.data_vld_out;
                obsRdData = bus.rd_data;
                done      = 1'b1;
            end
            @(negedge clk);
        end
        bus.data_main_vld = 1'b0;
    endtask

    task automatic applyFlush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        flush             = 1'b1;
        bus.addr          = '0;
        bus.addr_en       = 1'b0;
        bus.is_rd         = 1'b0;
        bus.wr_data       = '0;
        bus.data_vld      = 1'b0;
        bus.data_main_rd  = '0;
        bus.data_main_vld = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b0;

        checkOutput("rst_busy",     bus.cache_busy, 0);
        checkOutput("rst_resp",     bus.resp_vld, 0);
        checkOutput("rst_hit",      bus.is_hit, 0);
        checkOutput("rst_dvo",      bus.data_vld_out, 0);
        checkOutput("rst_rd_data",  bus.rd_data, 0);
        checkOutput("rst_addr",     bus.addr_main, 0);
        checkOutput("rst_rd_en",    bus.addr_main_rd_en, 0);
        checkOutput("rst_wr_en",    bus.addr_main_wr_en, 0);
        checkOutput("rst_wr_line",  bus.data_main_wr, 0);
        checkOutput("rst_hit_cnt",  bus.hit_count, 0);
        checkOutput("rst_miss_cnt", bus.miss_count, 0);

        applyStimulus(16'h0011, 1'b1, 8'h00, 32'hDDCCBBAA);
        checkOutput("cold_cycle",   obsCycle, 4);
        checkOutput("cold_rd_en",   obsSawRd, 1);
        checkOutput("cold_addr",    obsRdAddr, 16'h0010);
        checkOutput("cold_wr_en",   obsSawWr, 0);
        checkOutput("cold_is_hit",  obsHit, 0);
        checkOutput("cold_dvo",     obsDvo, 1);
        checkOutput("cold_rd_data", obsRdData, 8'hBB);

        applyStimulus(16'h0013, 1'b1, 8'h00, 32'h0);
        checkOutput("hit_cycle",   obsCycle, 2);
        checkOutput("hit_is_hit",  obsHit, 1);
        checkOutput("hit_rd_data", obsRdData, 8'hDD);
        checkOutput("hit_no_fill", obsSawRd, 0);

        applyStimulus(16'h0020, 1'b0, 8'h5A, 32'h44332211);
        checkOutput("wa_cycle",  obsCycle, 4);
        checkOutput("wa_is_hit", obsHit, 0);
        checkOutput("wa_dvo",    obsDvo, 0);
        checkOutput("wa_addr",   obsRdAddr, 16'h0020);
        applyStimulus(16'h0020, 1'b1, 8'h00, 32'h0);
        checkOutput("wa_rd_hit",  obsHit, 1);
        checkOutput("wa_rd_data", obsRdData, 8'h5A);
        checkOutput("wa_no_wb",   obsSawWr, 0);
        checkOutput("wa_hit_cnt",  bus.hit_count, 2);
        checkOutput("wa_miss_cnt", bus.miss_count, 2);

        applyFlush();
        checkOutput("flush_hit_cnt",  bus.hit_count, 0);
        checkOutput("flush_miss_cnt", bus.miss_count, 0);
        applyStimulus(16'h0000, 1'b0, 8'h11, 32'hA3A2A1A0);
        applyStimulus(16'h0010, 1'b0, 8'h22, 32'hB3B2B1B0);
        applyStimulus(16'h0020, 1'b1, 8'h00, 32'h0F0E0D0C);
        checkOutput("ev_cycle",    obsCycle, 6);
        checkOutput("ev_wr_en",    obsSawWr, 1);
        checkOutput("ev_wb_addr",  obsWrAddr, 16'h0000);
        checkOutput("ev_wb_line",  obsWrLine, 32'hA3A2A111);
        checkOutput("ev_fill",     obsRdAddr, 16'h0020);
        checkOutput("ev_rd_data",  obsRdData, 8'h0C);
        checkOutput("ev_is_hit",   obsHit, 0);
        applyStimulus(16'h0010, 1'b1, 8'h00, 32'h0);
        checkOutput("ev_keep_hit",  obsHit, 1);
        checkOutput("ev_keep_data", obsRdData, 8'h22);
        checkOutput("ev_keep_cyc",  obsCycle, 2);
        applyStimulus(16'h0020, 1'b1, 8'h00, 32'h0);
        checkOutput("ev_new_data", obsRdData, 8'h0C);
        applyStimulus(16'h0021, 1'b1, 8'h00, 32'h0);
        checkOutput("ev_b1_data", obsRdData, 8'h0D);
        applyStimulus(16'h0022, 1'b1, 8'h00, 32'h0);
        checkOutput("ev_b2_data", obsRdData, 8'h0E);
        applyStimulus(16'h0011, 1'b1, 8'h00, 32'h0);
        checkOutput("ev_b1_old", obsRdData, 8'hB1);
        checkOutput("cnt_hit",      bus.hit_count, 5);
        checkOutput("cnt_miss",     bus.miss_count, 3);
        checkOutput("cnt_sat_hit",  bus2.hit_count, 3);
        checkOutput("cnt_sat_miss", bus2.miss_count, 3);

        applyFlush();
        bus.addr    = 16'h0041;
        bus.is_rd   = 1'b1;
        bus.addr_en = 1'b1;
        @(negedge clk);
        bus.addr_en = 1'b0;
        checkOutput("mm_busy", bus.cache_busy, 1);
        @(negedge clk);
        checkOutput("mm_rd_en", bus.addr_main_rd_en, 1);
        checkOutput("mm_addr",  bus.addr_main, 16'h0040);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("mm_busy_after", bus.cache_busy, 0);
        checkOutput("mm_addr_clear", bus.addr_main, 0);
        bus.data_main_vld = 1'b1;
        bus.data_main_rd  = 32'h12345678;
        @(negedge clk);
        bus.data_main_vld = 1'b0;
        checkOutput("mm_late_resp", bus.resp_vld, 0);
        checkOutput("mm_late_busy", bus.cache_busy, 0);
        applyStimulus(16'h0041, 1'b1, 8'h00, 32'h99887766);
        checkOutput("mm_reread_hit",  obsHit, 0);
        checkOutput("mm_reread_cyc",  obsCycle, 4);
        checkOutput("mm_reread_data", obsRdData, 8'h77);

        sawTraffic   = 1'b0;
        bus.addr     = 16'h0050;
        bus.is_rd    = 1'b0;
        bus.wr_data  = 8'hEE;
        bus.data_vld = 1'b0;
        bus.addr_en  = 1'b1;
        @(negedge clk);
        bus.addr_en  = 1'b0;
        checkOutput("ign_wr_busy", bus.cache_busy, 0);
        bus.addr    = 16'h0042;
        bus.is_rd   = 1'b1;
        bus.addr_en = 1'b1;
        @(negedge clk);
        bus.addr = 16'h0080;
        checkOutput("ign_busy_lookup", bus.cache_busy, 1);
        @(negedge clk);
        bus.addr_en = 1'b0;
        checkOutput("ign_resp",    bus.resp_vld, 1);
        checkOutput("ign_is_hit",  bus.is_hit, 1);
        checkOutput("ign_rd_data", bus.rd_data, 8'h88);
        repeat (4) begin
            @(negedge clk);
            sawTraffic = sawTraffic | bus.addr_main_rd_en | bus.addr_main_wr_en | bus.cache_busy;
        end
        checkOutput("ign_traffic",  sawTraffic, 0);
        checkOutput("ign_hit_cnt",  bus.hit_count, 1);
        checkOutput("ign_miss_cnt", bus.miss_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
